cp0_nested_exc: RTL and testbench

- Parametrised coprocessor-0 for the pipelined MIPS core.
- Holds Status/Cause/EPC/Count/Compare and arbitrates synchronous exceptions, external interrupts and a timer interrupt.
- Supports nested exceptions through a status stack and an EPC stack of configurable depth.
- Sits beside the ID/EX stage; drives a registered redirect to the PC unit.

---
 rtl/cp0_pkg.sv | 45 ++++
 rtl/cp0_irq_sync.sv | 34 +++
 rtl/cp0_nested_exc.sv | 190 +++++++++++++++++++
 tb/tb_cp0_nested_exc.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared definitions for the coprocessor-0 block.
// Register indices, exception codes, Status/Cause field positions, the
// width of one saved Status field and the default exception vector.
package cp0_pkg;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    typedef enum logic [4:0] {
        EXC_INT = 5'd0,
        EXC_SYS = 5'd8,
        EXC_BRK = 5'd9,
        EXC_OV  = 5'd12,
        EXC_TEQ = 5'd13
    } exc_code_e;

    // Status active field layout; one saved field has the same width.
    localparam int FIELD_W   = 5;
    localparam int ST_IE     = 0;
    localparam int ST_SYS_EN = 1;
    localparam int ST_BRK_EN = 2;
    localparam int ST_OV_EN  = 3;
    localparam int ST_TEQ_EN = 4;
    localparam int ST_IM_LSB = 24;

    // Cause layout.
    localparam int CA_IP_LSB = 8;

    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0040_0004;

    // Codes with a dedicated enable bit need it; any other code needs only IE.
    function automatic logic exc_enabled(input logic [4:0] active, input logic [4:0] code);
        case (code)
            EXC_SYS: return active[ST_SYS_EN];
            EXC_BRK: return active[ST_BRK_EN];
            EXC_OV:  return active[ST_OV_EN];
            EXC_TEQ: return active[ST_TEQ_EN];
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/cp0_irq_sync.sv
// Multi-flop synchroniser for the asynchronous external interrupt lines.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   irq_i       - raw level interrupts (NUM_IRQ lines)
//   ip_hw_o     - synchronised levels as Cause.IP[6:2]; lines beyond NUM_IRQ read 0
module cp0_irq_sync #(
    parameter int NUM_IRQ     = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_i,
    output logic [4:0]         ip_hw_o
);

    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= irq_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    always_comb begin
        ip_hw_o = '0;
        ip_hw_o[NUM_IRQ-1:0] = sync_q[SYNC_STAGES-1];
    end

endmodule

// File: rtl/cp0_nested_exc.sv
// Coprocessor 0 with nested exception support.
// Holds Status/Cause/EPC/Count/Compare, arbitrates synchronous exceptions,
// external and timer interrupts and eret, and issues a registered one-cycle
// redirect to the PC unit. Status keeps a stack of saved 5-bit fields and
// EPC is a LIFO whose top is the architectural EPC register.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   mtc0, addr, wdata     - register write; addr also selects rdata
//   eret                  - exception return
//   pc                    - PC saved on exception entry
//   exc_valid, exc_code   - synchronous exception request and its code
//   irq                   - asynchronous level interrupts
//   rdata, status         - combinational register read, current Status
//   redirect, redirect_pc - one-cycle PC redirect and its target
//   nest_level            - current exception depth
//   exc_overflow          - pulse when an exception is dropped at full depth
module cp0_nested_exc
    import cp0_pkg::*;
#(
    parameter int          NEST_DEPTH  = 3,
    parameter int          NUM_IRQ     = 5,
    parameter logic [31:0] EXC_VECTOR  = DEFAULT_EXC_VECTOR,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              mtc0,
    input  logic                              eret,
    input  logic [4:0]                        addr,
    input  logic [31:0]                       wdata,
    input  logic [31:0]                       pc,
    input  logic                              exc_valid,
    input  logic [4:0]                        exc_code,
    input  logic [NUM_IRQ-1:0]                irq,
    output logic [31:0]                       rdata,
    output logic [31:0]                       status,
    output logic                              redirect,
    output logic [31:0]                       redirect_pc,
    output logic [$clog2(NEST_DEPTH+1)-1:0]   nest_level,
    output logic                              exc_overflow
);

    localparam int             SW      = FIELD_W * NEST_DEPTH;
    localparam int             LVL_W   = $clog2(NEST_DEPTH + 1);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(NEST_DEPTH);

    logic [31:0]                  status_q, status_d;
    logic [31:0]                  count_q, count_d;
    logic [31:0]                  compare_q, compare_d;
    logic [1:0]                   swip_q, swip_d;
    logic                         tip_q, tip_d;
    logic                         armed_q;
    logic [4:0]                   exccode_q, exccode_d;
    logic [NEST_DEPTH-1:0][31:0]  epc_q, epc_d;
    logic [31:0]                  gpr_q [32];
    logic                         gpr_we;
    logic [LVL_W-1:0]             level_q, level_d;
    logic                         redirect_q, redirect_d;
    logic [31:0]                  redirect_pc_q, redirect_pc_d;
    logic                         ovf_q, ovf_d;

    logic [4:0]  ip_hw;
    logic [7:0]  ip;
    logic        room, take_exc, take_int, do_eret, do_mtc0;

    cp0_irq_sync #(
        .NUM_IRQ     (NUM_IRQ),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .irq_i   (irq),
        .ip_hw_o (ip_hw)
    );

    assign ip   = {tip_q, ip_hw, swip_q};
    assign room = (level_q != LVL_MAX);

    // Fixed priority: sync exception > interrupt > eret > mtc0.
    assign take_exc = exc_valid && status_q[ST_IE] && room && exc_enabled(status_q[4:0], exc_code);
    assign take_int = !take_exc && status_q[ST_IE] && room && (|(ip & status_q[31:ST_IM_LSB]));
    assign do_eret  = eret && !take_exc && !take_int;
    assign do_mtc0  = mtc0 && !take_exc && !take_int && !eret;

    always_comb begin
        status_d      = status_q;
        count_d       = count_q + 32'd1;
        compare_d     = compare_q;
        swip_d        = swip_q;
        // armed_q masks the Count==Compare==0 coincidence on the first cycle out of reset.
        tip_d         = tip_q | (armed_q && (count_q == compare_q));
        exccode_d     = exccode_q;
        epc_d         = epc_q;
        level_d       = level_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        ovf_d         = exc_valid && status_q[ST_IE] && !room;
        gpr_we        = 1'b0;

        if (take_exc || take_int) begin
            status_d[SW-1:0] = status_q[SW-1:0] << FIELD_W;
            exccode_d        = take_exc ? exc_code : EXC_INT;
            for (int i = NEST_DEPTH - 1; i > 0; i--) begin
                epc_d[i] = epc_q[i-1];
            end
            epc_d[0]      = pc;
            level_d       = level_q + LVL_W'(1);
            redirect_d    = 1'b1;
            redirect_pc_d = EXC_VECTOR;
        end else if (do_eret) begin
            status_d[SW-1:0] = status_q[SW-1:0] >> FIELD_W;
            redirect_d       = 1'b1;
            redirect_pc_d    = epc_q[0];
            // An empty stack keeps its EPC so repeated erets return to the same place.
            if (level_q != '0) begin
                for (int i = 0; i < NEST_DEPTH - 1; i++) begin
                    epc_d[i] = epc_q[i+1];
                end
                epc_d[NEST_DEPTH-1] = '0;
                level_d             = level_q - LVL_W'(1);
            end
        end else if (do_mtc0) begin
            case (addr)
                REG_COUNT:   count_d = wdata;
                REG_COMPARE: begin
                    compare_d = wdata;
                    tip_d     = 1'b0;
                end
                REG_STATUS:  status_d = wdata;
                REG_CAUSE:   swip_d = wdata[CA_IP_LSB +: 2];
                REG_EPC:     epc_d[0] = wdata;
                default:     gpr_we = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q      <= '0;
            count_q       <= '0;
            compare_q     <= '0;
            swip_q        <= '0;
            tip_q         <= 1'b0;
            armed_q       <= 1'b0;
            exccode_q     <= '0;
            epc_q         <= '0;
            level_q       <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            ovf_q         <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                gpr_q[i] <= '0;
            end
        end else begin
            status_q      <= status_d;
            count_q       <= count_d;
            compare_q     <= compare_d;
            swip_q        <= swip_d;
            tip_q         <= tip_d;
            armed_q       <= 1'b1;
            exccode_q     <= exccode_d;
            epc_q         <= epc_d;
            level_q       <= level_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            ovf_q         <= ovf_d;
            if (gpr_we) begin
                gpr_q[addr] <= wdata;
            end
        end
    end

    always_comb begin
        case (addr)
            REG_COUNT:   rdata = count_q;
            REG_COMPARE: rdata = compare_q;
            REG_STATUS:  rdata = status_q;
            REG_CAUSE:   rdata = {16'h0, ip, 1'b0, exccode_q, 2'b00};
            REG_EPC:     rdata = epc_q[0];
            default:     rdata = gpr_q[addr];
        endcase
    end

    assign status       = status_q;
    assign redirect     = redirect_q;
    assign redirect_pc  = redirect_pc_q;
    assign nest_level   = level_q;
    assign exc_overflow = ovf_q;

endmodule

// File: tb/tb_cp0_nested_exc.sv
module tb_cp0_nested_exc;

    localparam int          NEST = 3;
    localparam int          NIRQ = 5;
    localparam int          SYNC = 2;
    localparam logic [31:0] VEC  = 32'h0040_0004;
    localparam logic [31:0] LOWMASK = 32'h0000_7FFF;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            mtc0 = 1'b0;
    logic            eret = 1'b0;
    logic            exc_valid = 1'b0;
    logic [4:0]      addr = '0;
    logic [4:0]      exc_code = '0;
    logic [31:0]     wdata = '0;
    logic [31:0]     pc = '0;
    logic [NIRQ-1:0] irq = '0;
    logic [31:0]     rdata, status, redirect_pc;
    logic            redirect, exc_overflow;
    logic [1:0]      nest_level;

    cp0_nested_exc #(
        .NEST_DEPTH  (NEST),
        .NUM_IRQ     (NIRQ),
        .EXC_VECTOR  (VEC),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mtc0         (mtc0),
        .eret         (eret),
        .addr         (addr),
        .wdata        (wdata),
        .pc           (pc),
        .exc_valid    (exc_valid),
        .exc_code     (exc_code),
        .irq          (irq),
        .rdata        (rdata),
        .status       (status),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .nest_level   (nest_level),
        .exc_overflow (exc_overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model state
    logic [31:0] m_status, m_count, m_compare, m_rpc;
    logic [31:0] m_regs [32];
    logic [1:0]  m_swip;
    logic        m_tip, m_armed, m_redir, m_ovf;
    logic [4:0]  m_exc;
    logic [31:0] m_epc [$];
    logic [4:0]  m_hist [$];
    int          m_level;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 50) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_status = '0; m_count = '0; m_compare = '0; m_rpc = '0;
        m_swip = '0; m_tip = 1'b0; m_armed = 1'b0; m_redir = 1'b0; m_ovf = 1'b0;
        m_exc = '0; m_level = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_epc = {};
        for (int i = 0; i < NEST; i++) m_epc.push_back(32'h0);
        m_hist = {};
        for (int i = 0; i < SYNC; i++) m_hist.push_back(5'h0);
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        logic [7:0] ipv;
        ipv = {m_tip, m_hist[0], m_swip};
        case (a)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return {16'h0, ipv, 1'b0, m_exc, 2'b00};
            5'd14:   return m_epc[0];
            default: return m_regs[a];
        endcase
    endfunction

    // Apply the current inputs for one clock, advance the model, compare outputs.
    task automatic step();
        logic ie, room, en, t_exc, t_int, d_eret, d_mtc0, n_tip;
        logic [7:0]  ipv;
        logic [31:0] low;
        ipv  = {m_tip, m_hist[0], m_swip};
        ie   = m_status[0];
        room = (m_level < NEST);
        case (exc_code)
            5'd8:    en = m_status[1];
            5'd9:    en = m_status[2];
            5'd12:   en = m_status[3];
            5'd13:   en = m_status[4];
            default: en = 1'b1;
        endcase
        t_exc  = exc_valid && ie && room && en;
        t_int  = !t_exc && ie && room && ((ipv & m_status[31:24]) != 8'h0);
        d_eret = eret && !t_exc && !t_int;
        d_mtc0 = mtc0 && !t_exc && !t_int && !eret;
        m_ovf  = exc_valid && ie && !room;
        n_tip  = m_tip || (m_armed && (m_count == m_compare));
        m_armed = 1'b1;
        m_count = m_count + 32'd1;
        m_tip   = n_tip;
        m_hist.push_back(irq);
        void'(m_hist.pop_front());
        m_redir = 1'b0;
        low = m_status & LOWMASK;
        if (t_exc || t_int) begin
            m_status = (m_status & ~LOWMASK) | ((low << 5) & LOWMASK);
            m_exc = t_exc ? exc_code : 5'd0;
            m_epc.push_front(pc);
            void'(m_epc.pop_back());
            m_level++;
            m_redir = 1'b1;
            m_rpc = VEC;
        end else if (d_eret) begin
            m_status = (m_status & ~LOWMASK) | (low >> 5);
            m_redir = 1'b1;
            m_rpc = m_epc[0];
            if (m_level > 0) begin
                void'(m_epc.pop_front());
                m_epc.push_back(32'h0);
                m_level--;
            end
        end else if (d_mtc0) begin
            case (addr)
                5'd9:  m_count = wdata;
                5'd11: begin m_compare = wdata; m_tip = 1'b0; end
                5'd12: m_status = wdata;
                5'd13: m_swip = wdata[9:8];
                5'd14: m_epc[0] = wdata;
                default: m_regs[addr] = wdata;
            endcase
        end
        @(posedge clk);
        #1;
        chk("redirect", 32'(redirect), 32'(m_redir));
        chk("redirect_pc", redirect_pc, m_rpc);
        chk("exc_overflow", 32'(exc_overflow), 32'(m_ovf));
        chk("nest_level", 32'(nest_level), 32'(m_level));
        chk("status", status, m_status);
        chk($sformatf("rdata[%0d]", addr), rdata, m_read(addr));
    endtask

    task automatic idle_inputs();
        mtc0 = 1'b0; eret = 1'b0; exc_valid = 1'b0;
    endtask

    task automatic do_reset();
        logic [4:0] al [6];
        al = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
        rst_n = 1'b0;
        idle_inputs();
        irq = '0; addr = '0; wdata = '0; pc = '0; exc_code = '0;
        m_reset();
        #1;
        chk("rst_redirect", 32'(redirect), 32'h0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        chk("rst_overflow", 32'(exc_overflow), 32'h0);
        chk("rst_status", status, 32'h0);
        chk("rst_nest", 32'(nest_level), 32'h0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            addr = al[i];
            #1;
            chk($sformatf("rst_rdata[%0d]", addr), rdata, 32'h0);
        end
        rst_n = 1'b1;
        addr = '0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        idle_inputs();
        mtc0 = 1'b1; addr = a; wdata = d;
        step();
        mtc0 = 1'b0;
    endtask

    task automatic take(input logic [4:0] code, input logic [31:0] p);
        idle_inputs();
        exc_valid = 1'b1; exc_code = code; pc = p;
        step();
        exc_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] cnt_before;
        logic [4:0]  codes [4];
        int          n;
        codes = '{5'd8, 5'd9, 5'd12, 5'd13};

        do_reset();

        // Single exception entry
        wr(5'd12, 32'h0000_0003);
        take(5'd8, 32'h0040_0100);
        chk("tp1_redirect", 32'(redirect), 32'h1);
        chk("tp1_redirect_pc", redirect_pc, 32'h0040_0004);
        chk("tp1_status", status, 32'h0000_0060);
        chk("tp1_nest", 32'(nest_level), 32'h1);
        addr = 5'd14; #1;
        chk("tp1_epc", rdata, 32'h0040_0100);
        addr = 5'd13; #1;
        chk("tp1_exccode", 32'(rdata[6:2]), 32'd8);

        // Reset while the redirect is being presented cancels it
        #2 rst_n = 1'b0;
        #1 chk("rst_cancel_redirect", 32'(redirect), 32'h0);
        do_reset();

        // Nested run up to full depth, overflow, then LIFO returns
        wr(5'd12, 32'h0000_001F);
        for (int k = 0; k < 3; k++) begin
            take(5'd8, 32'h0000_1000 + 32'(4 * k));
            wr(5'd12, m_status | 32'h1F);
        end
        chk("nest_full", 32'(nest_level), 32'd3);
        take(5'd8, 32'h0000_2000);
        chk("ovf_pulse", 32'(exc_overflow), 32'h1);
        chk("ovf_no_redirect", 32'(redirect), 32'h0);
        idle_inputs();
        step();
        chk("ovf_one_cycle", 32'(exc_overflow), 32'h0);
        for (int k = 2; k >= 0; k--) begin
            idle_inputs();
            eret = 1'b1;
            step();
            chk("nest_eret_pc", redirect_pc, 32'h0000_1000 + 32'(4 * k));
        end
        chk("nest_empty", 32'(nest_level), 32'd0);
        eret = 1'b1;
        step();
        eret = 1'b0;

        // Same-cycle priority: exception wins over eret and mtc0
        do_reset();
        wr(5'd12, 32'h0000_0005);
        cnt_before = m_count;
        exc_valid = 1'b1; exc_code = 5'd9; pc = 32'h0040_0200;
        eret = 1'b1; mtc0 = 1'b1; addr = 5'd9; wdata = 32'hDEAD_BEEF;
        step();
        idle_inputs();
        chk("prio_count", rdata, cnt_before + 32'd1);
        chk("prio_nest", 32'(nest_level), 32'd1);
        chk("prio_redirect_pc", redirect_pc, VEC);
        addr = 5'd13; #1;
        chk("prio_exccode", 32'(rdata[6:2]), 32'd9);

        // External interrupt through the synchroniser
        do_reset();
        irq = 5'b00001;
        wr(5'd12, 32'h0400_0001);
        addr = 5'd13;
        step();
        chk("irq_ip2_set", 32'(rdata[10]), 32'h1);
        step();
        chk("irq_taken_nest", 32'(nest_level), 32'd1);
        chk("irq_exccode", 32'(rdata[6:2]), 32'd0);
        chk("irq_status", status, 32'h0400_0020);
        irq = '0;
        step();
        step();
        chk("irq_ip2_clear", 32'(rdata[10]), 32'h0);

        // Timer interrupt
        do_reset();
        wr(5'd11, 32'd20);
        wr(5'd9, 32'd10);
        wr(5'd12, 32'h8000_0001);
        addr = 5'd13;
        n = 0;
        while (nest_level == 2'd0 && n < 30) begin
            step();
            n++;
        end
        chk("timer_latency", 32'(n), 32'd11);
        chk("timer_ip7", 32'(rdata[15]), 32'h1);
        wr(5'd11, 32'd0);
        addr = 5'd13; #1;
        chk("timer_ip7_clear", 32'(rdata[15]), 32'h0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] w;
            int          r;
            if (i == 1500) do_reset();
            exc_valid = ($urandom_range(0, 9) == 0);
            r = $urandom_range(0, 4);
            exc_code = (r == 4) ? 5'($urandom_range(0, 31)) : codes[r];
            eret = ($urandom_range(0, 9) == 0);
            mtc0 = ($urandom_range(0, 2) == 0);
            pc = $urandom;
            w = $urandom;
            case ($urandom_range(0, 6))
                0: begin addr = 5'd9;  w = m_compare - 32'($urandom_range(0, 40)); end
                1: begin addr = 5'd11; w = m_count + 32'($urandom_range(2, 40)); end
                2: begin addr = 5'd12; w[0] = ($urandom_range(0, 3) != 0); end
                3: addr = 5'd13;
                4: addr = 5'd14;
                default: addr = 5'($urandom_range(0, 31));
            endcase
            wdata = w;
            if ($urandom_range(0, 19) == 0) irq = 5'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
